// File: rtl/ss_product_window_acc.sv
`default_nettype none
// ============================================================================
// Module   : ss_product_window_acc
// Function : Sums 2^L valid product samples and returns the sum and the window
//            mean over a valid/ready handshake. Define SS_ACC_ROUND_EN to
//            round the mean half up instead of truncating it.
// Revision : 1.0
// ============================================================================
module ss_product_window_acc #(
    parameter int PROD_W       = 8,
    parameter int MAX_LOG2_LEN = 10,
    parameter int ACC_W        = PROD_W + MAX_LOG2_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        log2_len,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum_out,
    output logic [PROD_W-1:0] mean_out
);

    localparam logic [3:0]              C_MAX_L    = 4'(MAX_LOG2_LEN);
    localparam logic [MAX_LOG2_LEN-1:0] C_CNT_ONES = '1;
    localparam logic [ACC_W:0]          C_MEAN_MAX = (ACC_W+1)'((1 << PROD_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_len;
    logic [ACC_W-1:0]        r_acc;
    logic [MAX_LOG2_LEN-1:0] r_cnt;

    logic [ACC_W-1:0]        w_sum_next;
    logic [MAX_LOG2_LEN-1:0] w_last_idx;
    logic                    w_last;
    logic [ACC_W:0]          w_biased;
    logic [ACC_W:0]          w_shift;
    logic [PROD_W-1:0]       w_mean;

    assign w_sum_next = r_acc + ACC_W'(prod_in);
    // Index of the final sample in the window: 2^L - 1
    assign w_last_idx = ~(C_CNT_ONES << r_len);
    assign w_last     = (r_cnt == w_last_idx);

`ifdef SS_ACC_ROUND_EN
    // Extra top bit keeps the half-LSB bias from wrapping
    assign w_biased = (r_len == 4'd0) ? {1'b0, w_sum_next}
                    : {1'b0, w_sum_next} + ((ACC_W+1)'(1) << (r_len - 4'd1));
`else
    assign w_biased = {1'b0, w_sum_next};
`endif

    assign w_shift = w_biased >> r_len;
    assign w_mean  = (w_shift > C_MEAN_MAX) ? C_MEAN_MAX[PROD_W-1:0]
                                            : w_shift[PROD_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            sum_out   <= '0;
            mean_out  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len   <= (log2_len > C_MAX_L) ? C_MAX_L : log2_len;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (prod_valid) begin
                        r_acc <= w_sum_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            sum_out   <= w_sum_next;
                            mean_out  <= w_mean;
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
